// File: rtl/bram_vec_adder_pkg.sv
// Shared definitions for the BRAM vector adder.
// Holds the sequencer state encoding and the default operand/address widths
// used by bram_vec_adder and its memory sub-module.
package bram_vec_adder_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    // IDLE  : waiting for start, operand writes and result reads allowed
    // RUN   : one A/B read issued per cycle, index 0..last
    // FLUSH : final result write drains out of the one-cycle pipe
    // DONE  : one-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bram_vec_adder_sp_bram.sv
// Single-port synchronous RAM, read-first, one-cycle read latency.
// Written in the plain template vendors map onto block RAM: no reset on the
// array or the output register, dout only updates on enabled cycles.
// Ports:
//   clk  - rising-edge clock
//   en   - port enable (read and/or write this cycle)
//   we   - write enable, qualified by en
//   addr - word address
//   din  - write data
//   dout - registered read data (old contents on a write cycle)
module sp_bram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/bram_vec_adder.sv
// Element-wise vector adder over three block RAMs: R[i] = A[i] + B[i] for
// i = 0..last_addr, optionally saturating.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data - operand load into A (sel=0) or B (sel=1),
//                         ignored while busy
//   start, last_addr    - launch a run over indices 0..last_addr (IDLE only)
//   busy                - high in RUN and FLUSH
//   done                - one-cycle pulse in DONE
//   ovf                 - sticky carry-out seen during the current/last run
//   rd_en/rd_addr       - result read, ignored while busy
//   rd_data             - result read data, one cycle after rd_en
module bram_vec_adder
    import bram_vec_adder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SAT    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam bit SAT_EN = (SAT != 0);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;        // element currently being read
    logic [ADDR_W-1:0] last_q;     // latched final index
    logic [ADDR_W-1:0] widx;       // element whose sum is written this cycle
    logic              wr_pend;    // a read was issued last cycle; write its sum now
    logic              ovf_q;
    logic              rd_live;    // R dout holds a fresh read result
    logic [DATA_W-1:0] rd_hold;

    logic              busy_c;
    logic              start_ok;
    logic              wr_ok;
    logic              rd_ok;
    logic              rd_issue;

    logic              a_en, a_we, b_en, b_we, r_en;
    logic [ADDR_W-1:0] ab_addr, r_addr;
    logic [DATA_W-1:0] a_dout, b_dout, r_dout, r_din;
    logic [DATA_W:0]   sum;

    // ---------------------------------------------------------------
    // Control qualifiers
    // ---------------------------------------------------------------
    assign busy_c   = (state == RUN) || (state == FLUSH);
    assign start_ok = (state == IDLE) && start;
    assign wr_ok    = wr_en && !busy_c;
    assign rd_ok    = rd_en && !busy_c;
    assign rd_issue = (state == RUN);

    assign busy = busy_c;
    assign done = (state == DONE);
    assign ovf  = ovf_q;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == last_q) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Index counter and one-deep write pipe. The counter parks at last_q
    // rather than incrementing, so a full-depth run never wraps to 0.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            last_q  <= '0;
            widx    <= '0;
            wr_pend <= 1'b0;
        end else begin
            wr_pend <= rd_issue;
            if (rd_issue) begin
                widx <= idx;
            end
            if (start_ok) begin
                idx    <= '0;
                last_q <= last_addr;
            end else if (rd_issue && (idx != last_q)) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Adder and saturation
    // ---------------------------------------------------------------
    assign sum   = {1'b0, a_dout} + {1'b0, b_dout};
    assign r_din = (SAT_EN && sum[DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            ovf_q <= 1'b0;
        end else if (wr_pend && sum[DATA_W]) begin
            ovf_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Result read port. R's output register cannot be reset and is
    // disturbed by result writes, so rd_data shows R dout only on the
    // cycle after an accepted read and a resettable copy otherwise.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_live <= 1'b0;
            rd_hold <= '0;
        end else begin
            rd_live <= rd_ok;
            rd_hold <= rd_data;
        end
    end

    assign rd_data = rd_live ? r_dout : rd_hold;

    // ---------------------------------------------------------------
    // Memory port muxing. Operand writes and RUN reads never overlap
    // (writes are blocked while busy); likewise result writes and host
    // reads of R.
    // ---------------------------------------------------------------
    assign a_we    = wr_ok && !wr_sel;
    assign b_we    = wr_ok && wr_sel;
    assign a_en    = a_we || rd_issue;
    assign b_en    = b_we || rd_issue;
    assign ab_addr = rd_issue ? idx : wr_addr;

    assign r_en    = wr_pend || rd_ok;
    assign r_addr  = wr_pend ? widx : rd_addr;

    sp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_a (
        .clk  (clk),
        .en   (a_en),
        .we   (a_we),
        .addr (ab_addr),
        .din  (wr_data),
        .dout (a_dout)
    );

    sp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_b (
        .clk  (clk),
        .en   (b_en),
        .we   (b_we),
        .addr (ab_addr),
        .din  (wr_data),
        .dout (b_dout)
    );

    sp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_r (
        .clk  (clk),
        .en   (r_en),
        .we   (wr_pend),
        .addr (r_addr),
        .din  (r_din),
        .dout (r_dout)
    );

endmodule

// File: tb/tb_bram_vec_adder.sv
// Directed bench for bram_vec_adder. Two instances share all inputs: dut0
// wraps (SAT=0), dut1 saturates (SAT=1). Latency is counted in clock edges
// starting with the edge that samples start.
module tb_bram_vec_adder;

    logic        clk;
    logic        rst_n;
    logic        wr_en, wr_sel;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [7:0]  last_addr;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [15:0] rd_data0, rd_data1;

    int tests;
    int fails;

    bram_vec_adder #(.DATA_W(16), .ADDR_W(8), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .last_addr(last_addr), .busy(busy0), .done(done0), .ovf(ovf0),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0)
    );

    bram_vec_adder #(.DATA_W(16), .ADDR_W(8), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .last_addr(last_addr), .busy(busy1), .done(done1), .ovf(ovf1),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r_wrap;
        logic [15:0] r_sat;
    } vec_t;

    vec_t tbl [7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wr(input logic sel, input logic [7:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick;
        rd_en = 1'b0;
    endtask

    // Wait for done with a bound; n already counts edges since start.
    task automatic wait_done(inout int n);
        while (!done0 && n < 600) begin
            tick;
            n++;
        end
    endtask

    task automatic run_add(input logic [7:0] last, input string name);
        int n;
        start = 1'b1; last_addr = last;
        tick;
        start = 1'b0;
        n = 1;
        chk({name, "_busy"}, 32'(busy0), 32'd1);
        wait_done(n);
        chk({name, "_lat"}, 32'(n), 32'(int'(last) + 3));
        chk({name, "_done1"}, 32'(done1), 32'd1);
        tick;
        chk({name, "_idle"}, 32'({busy0, done0}), 32'd0);
    endtask

    initial begin
        int n;
        int dcnt;
        tests = 0; fails = 0;

        tbl[0] = '{16'd1,    16'd10,   16'd11,   16'd11};
        tbl[1] = '{16'd2,    16'd20,   16'd22,   16'd22};
        tbl[2] = '{16'd3,    16'd30,   16'd33,   16'd33};
        tbl[3] = '{16'd4,    16'd40,   16'd44,   16'd44};
        tbl[4] = '{16'hFFFF, 16'h0002, 16'h0001, 16'hFFFF};
        tbl[5] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
        tbl[6] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFF};

        clk = 1'b0; rst_n = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; last_addr = '0; rd_en = 1'b0; rd_addr = '0;
        tick; tick;

        // Reset state
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_rd0", 32'(rd_data0), 32'd0);
        chk("rst_rd1", 32'(rd_data1), 32'd0);
        rst_n = 1'b1;
        tick;

        // Single-element overflow, wrap vs saturate
        wr(1'b0, 8'd0, 16'hFFFF);
        wr(1'b1, 8'd0, 16'h0002);
        run_add(8'd0, "ovf");
        chk("ovf_flag0", 32'(ovf0), 32'd1);
        chk("ovf_flag1", 32'(ovf1), 32'd1);
        rd(8'd0);
        chk("ovf_r0_wrap", 32'(rd_data0), 32'h0001);
        chk("ovf_r0_sat", 32'(rd_data1), 32'hFFFF);

        // Table: first four entries as the basic add, then all seven
        for (int i = 0; i < 7; i++) begin
            wr(1'b0, 8'(i), tbl[i].a);
            wr(1'b1, 8'(i), tbl[i].b);
        end
        run_add(8'd3, "basic");
        chk("basic_ovf0", 32'(ovf0), 32'd0);
        chk("basic_ovf1", 32'(ovf1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd(8'(i));
            chk($sformatf("basic_r%0d", i), 32'(rd_data0), 32'(tbl[i].r_wrap));
        end
        run_add(8'd6, "tbl");
        chk("tbl_ovf0", 32'(ovf0), 32'd1);
        chk("tbl_ovf1", 32'(ovf1), 32'd1);
        for (int i = 0; i < 7; i++) begin
            rd(8'(i));
            chk($sformatf("tbl_wrap_r%0d", i), 32'(rd_data0), 32'(tbl[i].r_wrap));
            chk($sformatf("tbl_sat_r%0d", i), 32'(rd_data1), 32'(tbl[i].r_sat));
        end

        // Full depth
        for (int i = 0; i < 256; i++) begin
            wr(1'b0, 8'(i), 16'(i));
            wr(1'b1, 8'(i), 16'(2 * i));
        end
        run_add(8'd255, "full");
        chk("full_ovf", 32'(ovf0), 32'd0);
        rd(8'd255);
        chk("full_r255", 32'(rd_data0), 32'd765);
        chk("full_r255_sat", 32'(rd_data1), 32'd765);
        rd(8'd0);
        chk("full_r0", 32'(rd_data0), 32'd0);
        rd(8'd128);
        chk("full_r128", 32'(rd_data0), 32'd384);

        // Busy blocking
        wr(1'b0, 8'd0, 16'd5);
        wr(1'b1, 8'd0, 16'd6);
        for (int i = 1; i < 8; i++) begin
            wr(1'b0, 8'(i), 16'(i * 100));
            wr(1'b1, 8'(i), 16'd0);
        end
        run_add(8'd0, "busy_pre");
        rd(8'd0);
        chk("busy_pre_r0", 32'(rd_data0), 32'd11);
        start = 1'b1; last_addr = 8'd7;
        tick;
        start = 1'b0; n = 1;
        tick; n++;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 16'hAAAA;
        start = 1'b1; last_addr = 8'd0;
        rd_en = 1'b1; rd_addr = 8'd5;
        tick; n++;
        wr_en = 1'b0; start = 1'b0; rd_en = 1'b0;
        chk("busy_rdhold", 32'(rd_data0), 32'd11);
        wait_done(n);
        chk("busy_lat", 32'(n), 32'd10);
        tick;
        chk("busy_rdhold_end", 32'(rd_data0), 32'd11);
        run_add(8'd0, "busy_chk");
        rd(8'd0);
        chk("busy_a0_kept", 32'(rd_data0), 32'd11);

        // Reset mid-run at index 2
        wr(1'b0, 8'd0, 16'hFFFF);
        wr(1'b1, 8'd0, 16'h0002);
        wr(1'b0, 8'd2, 16'd7);
        wr(1'b1, 8'd2, 16'd7);
        start = 1'b1; last_addr = 8'd7;
        tick;
        start = 1'b0;
        tick; tick;
        chk("mid_pre_ovf", 32'(ovf0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy0), 32'd0);
        chk("mid_done", 32'(done0), 32'd0);
        chk("mid_ovf0", 32'(ovf0), 32'd0);
        chk("mid_ovf1", 32'(ovf1), 32'd0);
        chk("mid_rd", 32'(rd_data0), 32'd0);
        tick;
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick;
            if (done0 || done1) dcnt++;
        end
        chk("mid_no_done", 32'(dcnt), 32'd0);
        rd(8'd0);
        chk("mid_r0_wrap", 32'(rd_data0), 32'h0001);
        chk("mid_r0_sat", 32'(rd_data1), 32'hFFFF);
        rd(8'd2);
        chk("mid_r2_old", 32'(rd_data0), 32'd200);
        run_add(8'd7, "mid_rerun");
        chk("mid_rerun_ovf", 32'(ovf0), 32'd1);
        rd(8'd2);
        chk("mid_rerun_r2", 32'(rd_data0), 32'd14);

        // Start and operand write in the same IDLE cycle
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 8'd0; wr_data = 16'h1234;
        start = 1'b1; last_addr = 8'd0;
        tick;
        wr_en = 1'b0; start = 1'b0; n = 1;
        wait_done(n);
        chk("simul_lat", 32'(n), 32'd3);
        tick;
        chk("simul_ovf", 32'(ovf0), 32'd0);
        rd(8'd0);
        chk("simul_r0", 32'(rd_data0), 32'h1236);
        chk("simul_r0_sat", 32'(rd_data1), 32'h1236);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
